fifo_rd_stream: RTL and testbench

Read-side streaming adapter for the circular FIFO: it drains entries through the controller's `rd`/`empty` handshake and the storage array's one-cycle registered read port, and presents them downstream as a valid/ready stream. A two-entry output buffer hides the read latency, so sustained throughput is one word per cycle under continuous `m_ready`.

---
 rtl/fifo_pkg.sv | 5 +
 rtl/fifo_skid_buf.sv | 42 ++++
 rtl/fifo_rd_stream.sv | 40 ++++
 tb/tb_fifo_rd_stream.sv | 126 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO word width and output-buffer depth
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry circular output buffer with head/tail pointers and count
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);
  logic [W-1:0] mem_q [SKID_DEPTH];
  logic [W-1:0] mem_d [SKID_DEPTH];
  logic         head_q, head_d, tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[tail_q] = din;
    head_d = clr ? 1'b0 : head_q ^ pop;
    tail_d = clr ? 1'b0 : tail_q ^ push;
    cnt_d  = clr ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q  <= '{default: '0};
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
  assign dout = mem_q[head_q];
  assign cnt  = cnt_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the FIFO read port into a valid/ready stream through a 2-entry buffer
module fifo_rd_stream #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            level
);
  logic       inflight_q, inflight_d, pop, capture;
  logic [1:0] occ;
  always_comb begin
    pop        = m_valid & m_ready;
    occ        = level + 2'(inflight_q);
    fifo_rd    = ~fifo_empty & ~flush & reset_n & ((occ - 2'(pop)) < 2'(fifo_pkg::SKID_DEPTH));
    capture    = inflight_q & ~flush;
    inflight_d = fifo_rd;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) inflight_q <= 1'b0;
    else          inflight_q <= inflight_d;
  end
  fifo_skid_buf #(.W(DATA_WIDTH)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (flush),
    .push    (capture),
    .pop     (pop),
    .din     (fifo_rdata),
    .dout    (m_data),
    .cnt     (level)
  );
  assign m_valid = level != 2'd0;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: table-driven per-cycle checks of fifo_rd_stream against a FIFO model
module tb_fifo_rd_stream;
  typedef struct {
    bit         rn;
    bit         rdy;
    bit         fl;
    bit         rd;
    bit         vld;
    bit         cd;
    logic [7:0] dat;
    logic [1:0] lvl;
  } vec_t;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd;
  logic [7:0] fifo_rdata = 8'h00;
  logic       flush = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic [1:0] level;
  logic [7:0] fq[$];
  vec_t       tv[$];
  int         errors = 0;
  int         checks = 0;
  fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_rdata (fifo_rdata),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .level      (level)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (fifo_rd && fq.size() > 0) fifo_rdata <= fq.pop_front();
  function automatic vec_t v(bit rn, bit rdy, bit fl, bit rd, bit vld, bit cd, logic [7:0] dat, logic [1:0] lvl);
    vec_t r;
    r.rn = rn; r.rdy = rdy; r.fl = fl; r.rd = rd; r.vld = vld; r.cd = cd; r.dat = dat; r.lvl = lvl;
    return r;
  endfunction
  task automatic chk(string name, int row, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask
  task automatic run(int a, int b);
    for (int i = a; i < b; i++) begin
      @(negedge clk);
      reset_n    = tv[i].rn;
      m_ready    = tv[i].rdy;
      flush      = tv[i].fl;
      fifo_empty = fq.size() == 0;
      #1;
      chk("fifo_rd", i, 8'(fifo_rd), 8'(tv[i].rd));
      chk("m_valid", i, 8'(m_valid), 8'(tv[i].vld));
      chk("level", i, 8'(level), 8'(tv[i].lvl));
      if (tv[i].cd) chk("m_data", i, m_data, tv[i].dat);
    end
  endtask
  initial begin
    tv.push_back(v(0,0,0, 0,0,1,8'h00,0));
    tv.push_back(v(1,0,0, 0,0,1,8'h00,0));
    tv.push_back(v(1,0,0, 0,0,0,8'h00,0));
    tv.push_back(v(1,1,0, 1,0,0,8'h00,0));
    tv.push_back(v(1,1,0, 0,0,0,8'h00,0));
    tv.push_back(v(1,1,0, 0,1,1,8'hA5,1));
    tv.push_back(v(1,1,0, 0,0,0,8'h00,0));
    tv.push_back(v(1,1,0, 1,0,0,8'h00,0));
    tv.push_back(v(1,1,0, 1,0,0,8'h00,0));
    for (int k = 2; k < 8; k++) tv.push_back(v(1,1,0, 1,1,1,8'(k-1),1));
    tv.push_back(v(1,1,0, 0,1,1,8'h07,1));
    tv.push_back(v(1,1,0, 0,1,1,8'h08,1));
    tv.push_back(v(1,1,0, 0,0,0,8'h00,0));
    tv.push_back(v(1,0,0, 1,0,0,8'h00,0));
    tv.push_back(v(1,0,0, 1,0,0,8'h00,0));
    tv.push_back(v(1,0,0, 0,1,1,8'h01,1));
    tv.push_back(v(1,0,0, 0,1,1,8'h01,2));
    tv.push_back(v(1,0,0, 0,1,1,8'h01,2));
    tv.push_back(v(1,1,0, 1,1,1,8'h01,2));
    tv.push_back(v(1,1,0, 1,1,1,8'h02,1));
    tv.push_back(v(1,1,0, 1,1,1,8'h03,1));
    tv.push_back(v(1,1,0, 0,1,1,8'h04,1));
    tv.push_back(v(1,1,0, 0,1,1,8'h05,1));
    tv.push_back(v(1,1,0, 0,0,0,8'h00,0));
    tv.push_back(v(1,1,0, 1,0,0,8'h00,0));
    tv.push_back(v(1,1,1, 0,0,0,8'h00,0));
    tv.push_back(v(1,1,0, 1,0,0,8'h00,0));
    tv.push_back(v(1,1,0, 1,0,0,8'h00,0));
    tv.push_back(v(1,1,0, 0,1,1,8'h22,1));
    tv.push_back(v(1,1,0, 0,1,1,8'h33,1));
    tv.push_back(v(1,1,0, 0,0,0,8'h00,0));
    tv.push_back(v(1,0,0, 1,0,0,8'h00,0));
    tv.push_back(v(1,0,0, 1,0,0,8'h00,0));
    tv.push_back(v(1,0,0, 0,1,1,8'h41,1));
    tv.push_back(v(1,0,0, 0,1,1,8'h41,2));
    tv.push_back(v(0,0,0, 0,1,1,8'h41,2));
    tv.push_back(v(0,0,0, 0,0,1,8'h00,0));
    tv.push_back(v(1,1,0, 1,0,0,8'h00,0));
    tv.push_back(v(1,1,0, 0,0,0,8'h00,0));
    tv.push_back(v(1,1,0, 0,1,1,8'h43,1));
    tv.push_back(v(1,1,0, 0,0,0,8'h00,0));
    @(negedge clk);
    reset_n = 1'b0;
    run(0, 3);
    fq = '{8'hA5};
    run(3, 7);
    fq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run(7, 18);
    fq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run(18, 29);
    fq = '{8'h11, 8'h22, 8'h33};
    run(29, 36);
    fq = '{8'h41, 8'h42, 8'h43};
    run(36, 46);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
